load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the byte-addressed, big-endian, word-wide data memory in the PA2 processor.
- Turns pipeline load/store requests (byte, halfword, word; signed and unsigned) into full-word data-memory accesses, with extraction and sign/zero extension on loads.
- Data memory writes only whole words, so sub-word stores use a read-modify-write sequence.
- Flags misaligned and out-of-range accesses; the memory is never touched for a flagged request.

Parameters:
- DM_BYTES, 128, data memory size in bytes; valid byte addresses are 0 .. DM_BYTES-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (load only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; B uses [7:0], H uses [15:0].
- done  out  1  one-cycle pulse: request finished.
- err  out  1  valid with done: misaligned, out-of-range or illegal size.
- rd_data  out  32  extended load result; updated only on a successful load.
- MemAddr  out  32  word-aligned address, {req_addr[31:2], 2'b00}.
- MemWriteData  out  32  word to write.
- MemWrite  out  1  memory write strobe; memory writes on the falling edge.
- MemRead  out  1  memory read strobe; memory registers data on the rising edge.
- MemReadData  in  32  registered memory read word; holds its value while MemRead is low.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - done, err, rd_data, MemAddr, MemWriteData, MemWrite and MemRead all go to 0.
  - req_ready goes to 1.
  - MemWrite and MemRead are decoded from state only (Moore), so they drop as soon as reset asserts.
  - Reset mid-operation abandons the request with no done pulse. A pending write is suppressed if reset asserts before the falling edge.
- Accept: on a rising edge with req_valid and req_ready high, the unit latches store, size, addr and wdata. Inputs are ignored in every other state.
- Error check at accept, in priority order:
  - Illegal size: 011, 110, 111, or a store with 100 or 101.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Out of range: addr+bytes > DM_BYTES.
  - On error: go to ERR. ERR drives done=1, err=1 for one cycle, then IDLE. No MemRead or MemWrite is asserted and rd_data is held.
- Byte order within a word: offset = addr[1:0]. Offset 0 maps to word[31:24], offset 3 to word[7:0]. Halfword offset 0 is [31:16]; offset 2 is [15:0].
- States: IDLE, RD, EXT, WR, MRG, ERR. Edges counted from the accept edge E0.
- Load: IDLE -> RD -> EXT -> IDLE.
  - RD: MemRead=1.
  - EXT: MemRead=0; extract and extend MemReadData; rd_data is registered at E2.
  - done=1 in the cycle after E2 (3-cycle latency).
- SW: IDLE -> WR -> IDLE.
  - WR: MemWrite=1, MemWriteData=wdata.
  - done in the cycle after E1.
- SB/SH (read-modify-write): IDLE -> RD -> MRG -> IDLE.
  - MRG: MemRead=0, MemWrite=1. MemWriteData is MemReadData with only the target byte/halfword replaced by wdata.
  - done in the cycle after E2.
- done and err are registered; done is high for exactly one cycle per accepted request.
- err=0 on every successful done.
- A new request may be accepted in the same cycle done is high, since the state is IDLE.
- MemAddr and MemWriteData hold their last values while idle. Only the strobes qualify them.

Test Plan:
- Preload word 0x10 with 0x812345F6. LB 0x10 -> rd_data 0xFFFFFF81, done 3 cycles after accept, err=0. LBU 0x13 -> 0x000000F6. LH 0x10 -> 0xFFFF8123. LHU 0x12 -> 0x000045F6.
- SB 0x11, wdata 0xAABBCCDD -> one read then one write of 0x81DD45F6 at MemAddr 0x10, done after 3 cycles. A following LW 0x10 returns 0x81DD45F6.
- SW 0x7C, wdata 0xDEADBEEF -> MemWrite high for exactly one cycle, done after 2 cycles. LW 0x80 -> err=1, with no strobes.
- SH 0x13 and LW 0x12 -> done=1, err=1 one cycle after accept; MemRead and MemWrite stay 0; rd_data and memory unchanged. req_size 110 -> err=1.
- req_valid held high across back-to-back LB then SB -> req_ready low while busy; second request accepted on the cycle the first done is high; no request lost or duplicated.
- Assert rst during MRG -> MemWrite drops immediately, target word unchanged, no done pulse, all outputs 0, req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Converts pipeline load/store requests (byte, halfword, word; signed and
//   unsigned loads) into whole-word accesses on a big-endian data memory.
//   Sub-word stores are done as read-modify-write. Misaligned, out-of-range
//   and illegal-size requests are rejected without touching memory.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_store         1 = store, 0 = load
//   req_size          000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr          byte address
//   req_wdata         store data (B uses [7:0], H uses [15:0])
//   done, err         one-cycle completion pulse, error flag valid with done
//   rd_data           extended load result
//   MemAddr           word-aligned memory address
//   MemWriteData      word written to memory
//   MemWrite/MemRead  memory strobes (decoded from state)
//   MemReadData       registered memory read word
module load_store_unit #(
    parameter int DM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rd_data,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] MemReadData
);

    typedef enum logic [2:0] {IDLE, RD, EXT, WR, MRG, ERR} state_t;

    state_t      st;
    logic        store_q;
    logic [2:0]  size_q;
    logic [1:0]  ofs_q;
    logic [31:0] wdata_q;
    logic [31:0] mwd_q;
    logic [31:0] merged;

    logic        illegal, misaligned, out_of_range, bad;
    logic [2:0]  nbytes;
    logic [32:0] end_addr;

    // Pick the addressed byte/halfword (offset 0 is the MSB end) and extend.
    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [2:0]  sz,
                                            input logic [1:0]  ofs);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (ofs)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = ofs[1] ? w[15:0] : w[31:16];
        case (sz)
            3'b000:  r = 32'($signed(b));
            3'b100:  r = {24'd0, b};
            3'b001:  r = 32'($signed(h));
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace only the target byte/halfword of the old memory word.
    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [31:0] d,
                                          input logic [2:0]  sz,
                                          input logic [1:0]  ofs);
        logic [31:0] r;
        r = w;
        if (sz == 3'b000) begin
            case (ofs)
                2'd0:    r[31:24] = d[7:0];
                2'd1:    r[23:16] = d[7:0];
                2'd2:    r[15:8]  = d[7:0];
                default: r[7:0]   = d[7:0];
            endcase
        end else if (sz == 3'b001) begin
            if (ofs[1]) r[15:0]  = d[15:0];
            else        r[31:16] = d[15:0];
        end
        return r;
    endfunction

    // Request screening, evaluated on the incoming request at accept time.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        nbytes     = 3'd1;
        case (req_size)
            3'b000:         nbytes = 3'd1;
            3'b001:         begin nbytes = 3'd2; misaligned = req_addr[0];          end
            3'b010:         begin nbytes = 3'd4; misaligned = |req_addr[1:0];       end
            3'b100:         begin nbytes = 3'd1; illegal = req_store;               end
            3'b101:         begin nbytes = 3'd2; illegal = req_store;
                                  misaligned = req_addr[0];                         end
            default:        illegal = 1'b1;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap into range
        end_addr     = {1'b0, req_addr} + {30'd0, nbytes};
        out_of_range = end_addr > 33'(DM_BYTES);
        bad          = illegal | misaligned | out_of_range;
    end

    assign merged       = merge(MemReadData, wdata_q, size_q, ofs_q);
    assign req_ready    = (st == IDLE);
    assign MemRead      = (st == RD);
    assign MemWrite     = (st == WR) || (st == MRG);
    // During MRG the merged word comes straight from the memory read data,
    // which is only valid from the start of that cycle.
    assign MemWriteData = (st == MRG) ? merged : mwd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            done    <= 1'b0;
            err     <= 1'b0;
            rd_data <= 32'd0;
            MemAddr <= 32'd0;
            mwd_q   <= 32'd0;
            store_q <= 1'b0;
            size_q  <= 3'd0;
            ofs_q   <= 2'd0;
            wdata_q <= 32'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (st)
                IDLE: begin
                    if (req_valid) begin
                        store_q <= req_store;
                        size_q  <= req_size;
                        ofs_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (bad) begin
                            st   <= ERR;
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            MemAddr <= {req_addr[31:2], 2'b00};
                            if (req_store && req_size == 3'b010) begin
                                mwd_q <= req_wdata;
                                st    <= WR;
                            end else begin
                                st <= RD;
                            end
                        end
                    end
                end
                RD:  st <= store_q ? MRG : EXT;
                EXT: begin
                    rd_data <= extract(MemReadData, size_q, ofs_q);
                    done    <= 1'b1;
                    st      <= IDLE;
                end
                WR: begin
                    done <= 1'b1;
                    st   <= IDLE;
                end
                MRG: begin
                    mwd_q <= merged;
                    done  <= 1'b1;
                    st    <= IDLE;
                end
                ERR:     st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        done, err;
    logic [31:0] rd_data, MemAddr, MemWriteData, MemReadData;
    logic        MemWrite, MemRead;

    logic [31:0] mem [32];
    int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    logic [31:0] last_waddr = 32'd0;

    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DM_BYTES(128)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .err(err), .rd_data(rd_data),
        .MemAddr(MemAddr), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
    );

    // Data memory model: registered read on rising edge, write on falling edge.
    always @(posedge clk) begin
        if (MemRead) MemReadData <= mem[MemAddr[6:2]];
    end

    always @(negedge clk) begin
        if (MemWrite) begin
            mem[MemAddr[6:2]] <= MemWriteData;
            last_waddr        <= MemAddr;
            wr_cnt            <= wr_cnt + 1;
        end
        if (MemRead) rd_cnt <= rd_cnt + 1;
        if (done)    done_cnt <= done_cnt + 1;
    end

    // Issue one request and wait (bounded) for done; latency counts falling
    // edges after the accept edge up to and including the one that sees done.
    task automatic issue(input logic st, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int nrd, output int nwr,
                         output logic e);
        int r0, w0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_size = sz;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        r0 = rd_cnt; w0 = wr_cnt;
        lat = 0; e = 1'bx;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                e = err;
                break;
            end
        end
        @(posedge clk);
        #1;
        nrd = rd_cnt - r0;
        nwr = wr_cnt - w0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0;
        req_size = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        #12;
        chk_cnt++;
        if ({done, err, MemWrite, MemRead, req_ready} !== 5'b00001)
            $display("FAIL reset_ctrl: got %b expected 00001", {done, err, MemWrite, MemRead, req_ready});
        else pass_cnt++;
        chk_cnt++;
        if ({rd_data, MemAddr, MemWriteData} !== 96'd0)
            $display("FAIL reset_data: got %h expected 0", {rd_data, MemAddr, MemWriteData});
        else pass_cnt++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_preload;
        int lat, nrd, nwr; logic e;
        issue(1'b1, SZ_W, 32'h10, 32'h812345F6, lat, nrd, nwr, e);
        issue(1'b1, SZ_W, 32'h20, 32'h11223344, lat, nrd, nwr, e);
        chk_cnt++;
        if (mem[4] !== 32'h812345F6 || mem[8] !== 32'h11223344)
            $display("FAIL preload: got %h %h expected 812345f6 11223344", mem[4], mem[8]);
        else pass_cnt++;
    endtask

    task automatic test_loads;
        int lat, nrd, nwr; logic e;
        issue(1'b0, SZ_B, 32'h10, 32'h0, lat, nrd, nwr, e);
        chk_cnt++;
        if (rd_data !== 32'hFFFFFF81 || lat != 3 || e !== 1'b0 || nrd != 1 || nwr != 0)
            $display("FAIL lb: got data %h lat %0d err %b rd %0d wr %0d expected ffffff81 3 0 1 0", rd_data, lat, e, nrd, nwr);
        else pass_cnt++;
        chk_cnt++;
        if (done !== 1'b0)
            $display("FAIL done_pulse: got %b expected 0", done);
        else pass_cnt++;
        issue(1'b0, SZ_BU, 32'h13, 32'h0, lat, nrd, nwr, e);
        chk_cnt++;
        if (rd_data !== 32'h000000F6 || e !== 1'b0)
            $display("FAIL lbu: got %h err %b expected 000000f6 0", rd_data, e);
        else pass_cnt++;
        issue(1'b0, SZ_H, 32'h10, 32'h0, lat, nrd, nwr, e);
        chk_cnt++;
        if (rd_data !== 32'hFFFF8123 || e !== 1'b0)
            $display("FAIL lh: got %h err %b expected ffff8123 0", rd_data, e);
        else pass_cnt++;
        issue(1'b0, SZ_HU, 32'h12, 32'h0, lat, nrd, nwr, e);
        chk_cnt++;
        if (rd_data !== 32'h000045F6 || e !== 1'b0)
            $display("FAIL lhu: got %h err %b expected 000045f6 0", rd_data, e);
        else pass_cnt++;
    endtask

    task automatic test_stores;
        int lat, nrd, nwr; logic e;
        issue(1'b1, SZ_B, 32'h11, 32'hAABBCCDD, lat, nrd, nwr, e);
        chk_cnt++;
        if (mem[4] !== 32'h81DD45F6 || lat != 3 || nrd != 1 || nwr != 1 || last_waddr !== 32'h10 || e !== 1'b0)
            $display("FAIL sb: got mem %h lat %0d rd %0d wr %0d addr %h err %b expected 81dd45f6 3 1 1 10 0", mem[4], lat, nrd, nwr, last_waddr, e);
        else pass_cnt++;
        issue(1'b0, SZ_W, 32'h10, 32'h0, lat, nrd, nwr, e);
        chk_cnt++;
        if (rd_data !== 32'h81DD45F6)
            $display("FAIL lw_after_sb: got %h expected 81dd45f6", rd_data);
        else pass_cnt++;
        issue(1'b1, SZ_W, 32'h7C, 32'hDEADBEEF, lat, nrd, nwr, e);
        chk_cnt++;
        if (mem[31] !== 32'hDEADBEEF || lat != 2 || nwr != 1 || nrd != 0 || e !== 1'b0)
            $display("FAIL sw_top: got mem %h lat %0d wr %0d rd %0d err %b expected deadbeef 2 1 0 0", mem[31], lat, nwr, nrd, e);
        else pass_cnt++;
        issue(1'b0, SZ_B, 32'h7F, 32'h0, lat, nrd, nwr, e);
        chk_cnt++;
        if (rd_data !== 32'hFFFFFFEF || e !== 1'b0)
            $display("FAIL lb_last_byte: got %h err %b expected ffffffef 0", rd_data, e);
        else pass_cnt++;
        issue(1'b0, SZ_HU, 32'h7E, 32'h0, lat, nrd, nwr, e);
        chk_cnt++;
        if (rd_data !== 32'h0000BEEF || e !== 1'b0)
            $display("FAIL lhu_last_half: got %h err %b expected 0000beef 0", rd_data, e);
        else pass_cnt++;
    endtask

    task automatic test_errors;
        int lat, nrd, nwr; logic e;
        issue(1'b0, SZ_W, 32'h80, 32'h0, lat, nrd, nwr, e);
        chk_cnt++;
        if (e !== 1'b1 || lat != 1 || nrd != 0 || nwr != 0 || rd_data !== 32'h0000BEEF)
            $display("FAIL lw_oor: got err %b lat %0d rd %0d wr %0d data %h expected 1 1 0 0 0000beef", e, lat, nrd, nwr, rd_data);
        else pass_cnt++;
        issue(1'b1, SZ_H, 32'h13, 32'h12345678, lat, nrd, nwr, e);
        chk_cnt++;
        if (e !== 1'b1 || lat != 1 || nrd != 0 || nwr != 0 || mem[4] !== 32'h81DD45F6)
            $display("FAIL sh_misaligned: got err %b lat %0d rd %0d wr %0d mem %h expected 1 1 0 0 81dd45f6", e, lat, nrd, nwr, mem[4]);
        else pass_cnt++;
        issue(1'b0, SZ_W, 32'h12, 32'h0, lat, nrd, nwr, e);
        chk_cnt++;
        if (e !== 1'b1 || lat != 1 || nrd != 0 || rd_data !== 32'h0000BEEF)
            $display("FAIL lw_misaligned: got err %b lat %0d rd %0d data %h expected 1 1 0 0000beef", e, lat, nrd, rd_data);
        else pass_cnt++;
        issue(1'b0, 3'b110, 32'h10, 32'h0, lat, nrd, nwr, e);
        chk_cnt++;
        if (e !== 1'b1 || lat != 1 || nrd != 0)
            $display("FAIL size110: got err %b lat %0d rd %0d expected 1 1 0", e, lat, nrd);
        else pass_cnt++;
        issue(1'b1, SZ_BU, 32'h10, 32'h0, lat, nrd, nwr, e);
        chk_cnt++;
        if (e !== 1'b1 || nwr != 0 || nrd != 0 || mem[4] !== 32'h81DD45F6)
            $display("FAIL store_bu: got err %b wr %0d rd %0d mem %h expected 1 0 0 81dd45f6", e, nwr, nrd, mem[4]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int d0, busy_ready, cyc;
        logic saw_done;
        d0 = done_cnt;
        busy_ready = 0;
        saw_done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_size = SZ_B;
        req_addr = 32'h12; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_store = 1'b1; req_addr = 32'h13; req_wdata = 32'h00000099;
        for (cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done) begin saw_done = 1'b1; break; end
            if (req_ready) busy_ready++;
        end
        chk_cnt++;
        if (!saw_done || cyc != 2 || busy_ready != 0 || req_ready !== 1'b1 || rd_data !== 32'h00000045)
            $display("FAIL b2b_first: got done %b cyc %0d ready_while_busy %0d ready %b data %h expected 1 2 0 1 00000045", saw_done, cyc, busy_ready, req_ready, rd_data);
        else pass_cnt++;
        @(posedge clk);
        #1 req_valid = 1'b0;
        saw_done = 1'b0;
        for (cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done) begin saw_done = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (!saw_done || cyc != 2 || mem[4] !== 32'h81DD4599 || done_cnt - d0 != 2)
            $display("FAIL b2b_second: got done %b cyc %0d mem %h pulses %0d expected 1 2 81dd4599 2", saw_done, cyc, mem[4], done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_rmw;
        int d0, lat, nrd, nwr; logic e;
        d0 = done_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = SZ_H;
        req_addr = 32'h22; req_wdata = 32'h00005555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (MemWrite !== 1'b1)
            $display("FAIL mrg_entered: got MemWrite %b expected 1", MemWrite);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({done, err, MemWrite, MemRead, req_ready} !== 5'b00001 || {rd_data, MemAddr, MemWriteData} !== 96'd0)
            $display("FAIL rst_mid_ctrl: got %b data %h expected 00001 and 0", {done, err, MemWrite, MemRead, req_ready}, {rd_data, MemAddr, MemWriteData});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (mem[8] !== 32'h11223344 || done_cnt != d0)
            $display("FAIL rst_mid_mem: got mem %h pulses %0d expected 11223344 0", mem[8], done_cnt - d0);
        else pass_cnt++;
        issue(1'b0, SZ_W, 32'h20, 32'h0, lat, nrd, nwr, e);
        chk_cnt++;
        if (rd_data !== 32'h11223344 || e !== 1'b0 || lat != 3)
            $display("FAIL after_rst_lw: got %h err %b lat %0d expected 11223344 0 3", rd_data, e, lat);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_preload;
        test_loads;
        test_stores;
        test_errors;
        test_back_to_back;
        test_reset_mid_rmw;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
